// File: rtl/pc_unit_if.sv
// pc_unit_if: request/response bundle between the fetch controller and pc_unit.
//   Requests (master -> slave): i_stall, i_zero, i_beq, i_bne, i_j, i_jal,
//     i_jr, i_ret, i_imm26, i_rs_addr.
//   Responses (slave -> master): o_pc, o_incPC, o_next_pc, o_PCSrc,
//     o_ras_empty, o_ras_full, o_ras_miss.
// PC_WIDTH must match the pc_unit instance it is bound to.
interface pc_unit_if #(
  parameter int PC_WIDTH = 30
);
  logic                i_stall;
  logic                i_zero;
  logic                i_beq;
  logic                i_bne;
  logic                i_j;
  logic                i_jal;
  logic                i_jr;
  logic                i_ret;
  logic [25:0]         i_imm26;
  logic [PC_WIDTH-1:0] i_rs_addr;

  logic [PC_WIDTH-1:0] o_pc;
  logic [PC_WIDTH-1:0] o_incPC;
  logic [PC_WIDTH-1:0] o_next_pc;
  logic                o_PCSrc;
  logic                o_ras_empty;
  logic                o_ras_full;
  logic                o_ras_miss;

  modport master (
    output i_stall, i_zero, i_beq, i_bne, i_j, i_jal, i_jr, i_ret,
           i_imm26, i_rs_addr,
    input  o_pc, o_incPC, o_next_pc, o_PCSrc, o_ras_empty, o_ras_full,
           o_ras_miss
  );

  modport slave (
    input  i_stall, i_zero, i_beq, i_bne, i_j, i_jal, i_jr, i_ret,
           i_imm26, i_rs_addr,
    output o_pc, o_incPC, o_next_pc, o_PCSrc, o_ras_empty, o_ras_full,
           o_ras_miss
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program-counter unit with a circular return-address stack.
//   Owns the PC register and selects the next fetch address from
//   sequential / branch / jump / register-jump / return requests.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst_n - asynchronous active-low reset
//   bus     - pc_unit_if.slave (requests in, PC / RAS status out)
// Parameters:
//   PC_WIDTH  - word-address width (26..32)
//   RESET_PC  - PC loaded on reset
//   RAS_DEPTH - return-stack entries (power of two, >= 2)
module pc_unit #(
  parameter int                  PC_WIDTH  = 30,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  RAS_DEPTH = 4
) (
  input logic     i_clk,
  input logic     i_rst_n,
  pc_unit_if.slave bus
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  // ---------------------------------------------------------------- state
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] ras_mem_q [RAS_DEPTH];

  // ---------------------------------------------------------- address math
  logic [PC_WIDTH-1:0] inc_pc;
  logic [PC_WIDTH-1:0] br_tgt;
  logic [PC_WIDTH-1:0] jmp_tgt;
  logic [PC_WIDTH-1:0] ras_top;
  logic [PTR_W-1:0]    ptr_inc;
  logic [PTR_W-1:0]    ptr_dec;

  assign inc_pc  = pc_q + PC_WIDTH'(1);
  assign br_tgt  = inc_pc + {{(PC_WIDTH-16){bus.i_imm26[15]}}, bus.i_imm26[15:0]};
  // Power-of-two depth lets the pointer wrap by plain overflow.
  assign ptr_inc = ptr_q + PTR_W'(1);
  assign ptr_dec = ptr_q - PTR_W'(1);
  assign ras_top = ras_mem_q[ptr_q];

  // Jump keeps the region bits above the 26-bit index, if there are any.
  generate
    if (PC_WIDTH == 26) begin : g_jmp_full
      assign jmp_tgt = bus.i_imm26;
    end else begin : g_jmp_region
      assign jmp_tgt = {inc_pc[PC_WIDTH-1:26], bus.i_imm26};
    end
  endgenerate

  // ------------------------------------------------------ request priority
  logic ras_empty;
  logic ras_full;
  logic sel_ret;
  logic sel_jr;
  logic sel_jal;
  logic sel_j;
  logic br_cond;
  logic sel_br;
  logic redirect;
  logic push;
  logic pop;

  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_FULL);

  assign sel_ret = bus.i_ret;
  assign sel_jr  = !bus.i_ret && bus.i_jr;
  assign sel_jal = !bus.i_ret && !bus.i_jr && bus.i_jal;
  assign sel_j   = !bus.i_ret && !bus.i_jr && !bus.i_jal && bus.i_j;
  assign br_cond = (bus.i_beq && bus.i_zero) || (bus.i_bne && !bus.i_zero);
  assign sel_br  = !bus.i_ret && !bus.i_jr && !bus.i_jal && !bus.i_j && br_cond;

  assign redirect = sel_ret || sel_jr || sel_jal || sel_j || sel_br;

  // Only the winning request may touch the stack, so push and pop are exclusive.
  assign push = sel_jal && !bus.i_stall;
  assign pop  = sel_ret && !ras_empty && !bus.i_stall;

  always_comb begin
    pc_d = inc_pc;
    if (sel_ret)                pc_d = ras_empty ? bus.i_rs_addr : ras_top;
    else if (sel_jr)            pc_d = bus.i_rs_addr;
    else if (sel_jal || sel_j)  pc_d = jmp_tgt;
    else if (sel_br)            pc_d = br_tgt;
  end

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_inc;
      // Overflow overwrites the oldest slot; occupancy saturates.
      if (!ras_full) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop) begin
      ptr_d = ptr_dec;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q  <= RESET_PC;
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (!bus.i_stall) begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Stack contents are don't-care after reset; the count guards every read.
  always_ff @(posedge i_clk) begin
    if (push) ras_mem_q[ptr_inc] <= inc_pc;
  end

  // --------------------------------------------------------------- outputs
  assign bus.o_pc        = pc_q;
  assign bus.o_incPC     = inc_pc;
  assign bus.o_next_pc   = pc_d;
  assign bus.o_PCSrc     = redirect && !bus.i_stall;
  assign bus.o_ras_empty = ras_empty;
  assign bus.o_ras_full  = ras_full;
  assign bus.o_ras_miss  = sel_ret && ras_empty && !bus.i_stall;

endmodule
